uart_alu_frame_engine: RTL

- Parametrised successor to the UART ALU datapath.
- Sits between a UART byte receiver and a UART byte transmitter.
- Parses command frames of DATA_W-bit operands, executes an extended ALU op, and queues the responses in a result FIFO.
- Serialises each response as a status byte followed by the result, and resynchronises on inter-byte timeout.

---
 rtl/uart_alu_frame_engine.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_alu_frame_engine.sv
// Frame-based UART ALU: parses {opcode, A, B} byte frames, executes the op,
// queues {status, result} responses and serialises them byte by byte.
module uart_alu_frame_engine #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned RESP_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 1041600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       frame_err,
    output logic       drop,
    output logic       busy
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned ENT_W = DATA_W + 8;
    localparam int unsigned AW    = $clog2(RESP_DEPTH);
    localparam int unsigned CW    = $clog2(RESP_DEPTH + 1);
    localparam int unsigned BCW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned IW    = $clog2(NB + 1);
    localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {P_OP, P_A, P_B, P_EXEC} p_state_t;
    typedef enum logic {T_IDLE, T_SEND} t_state_t;

    p_state_t            r_p_state;
    t_state_t            r_t_state;
    logic [7:0]          r_opcode;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [BCW-1:0]      r_byte_cnt;
    logic [TW-1:0]       r_tmo_cnt;
    logic                r_frame_err;
    logic                r_drop;
    logic                r_busy;

    logic [ENT_W-1:0]    r_mem [RESP_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic [7:0]          r_tx_data;
    logic                r_tx_valid;
    logic [DATA_W-1:0]   r_tx_buf;
    logic [IW-1:0]       r_tx_idx;

    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_rot;
    logic                w_oob;
    logic [DATA_W-1:0]   w_result;
    logic                w_carry;
    logic                w_bad;
    logic [7:0]          w_status;
    logic [ENT_W-1:0]    w_entry;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_hs;
    logic                w_last;
    logic                w_more;
    logic [ENT_W-1:0]    w_head;
    logic [ENT_W-1:0]    w_next;
    logic [DATA_W-1:0]   w_a_shift;
    logic [DATA_W-1:0]   w_b_shift;

    // Operand bytes arrive LSB-first, so each new byte enters at the top.
    assign w_a_shift = (r_a >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));
    assign w_b_shift = (r_b >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};
    assign w_rot = r_b % DATA_W'(DATA_W);
    assign w_oob = (r_b >= DATA_W'(DATA_W));

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        w_bad    = 1'b0;
        if (r_opcode[7:4] != 4'h0) begin
            w_bad = 1'b1;
        end else begin
            case (r_opcode[3:0])
                4'h0: begin
                    w_result = w_sum[DATA_W-1:0];
                    w_carry  = w_sum[DATA_W];
                end
                4'h1: begin
                    w_result = r_a - r_b;
                    w_carry  = (r_a < r_b);
                end
                4'h2: w_result = r_a & r_b;
                4'h3: w_result = r_a | r_b;
                4'h4: w_result = r_a ^ r_b;
                4'h5: w_result = w_oob ? '0 : (r_a << r_b);
                4'h6: w_result = w_oob ? '0 : (r_a >> r_b);
                4'h7: w_result = (r_a << w_rot) | (r_a >> (DATA_W'(DATA_W) - w_rot));
                4'h8: w_result = (r_a >> w_rot) | (r_a << (DATA_W'(DATA_W) - w_rot));
                4'h9: w_result = (r_a < r_b) ? r_a : r_b;
                4'hA: w_result = (r_a > r_b) ? r_a : r_b;
                default: w_bad = 1'b1;
            endcase
        end
    end

    // A rejected opcode reports only the bad-opcode flag.
    assign w_status = {5'b0, w_bad, ~w_bad & (w_result == '0), w_carry};
    assign w_entry  = {w_status, w_result};

    // The entry being serialised keeps its slot until its last byte is taken.
    assign w_full = (r_count == CW'(RESP_DEPTH));
    assign w_push = (r_p_state == P_EXEC) && !w_full;
    assign w_hs   = r_tx_valid && tx_ready;
    assign w_last = (r_tx_idx == IW'(NB));
    assign w_pop  = (r_t_state == T_SEND) && w_hs && w_last;
    assign w_more = (r_count > CW'(1)) || w_push;
    assign w_head = r_mem[r_rd_ptr];
    assign w_next = (r_count > CW'(1)) ? r_mem[r_rd_ptr + AW'(1)] : w_entry;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p_state   <= P_OP;
            r_opcode    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_byte_cnt  <= '0;
            r_tmo_cnt   <= '0;
            r_frame_err <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_drop      <= 1'b0;
            case (r_p_state)
                P_OP: begin
                    r_tmo_cnt <= '0;
                    if (rx_valid) begin
                        r_opcode   <= rx_data;
                        r_byte_cnt <= '0;
                        r_p_state  <= P_A;
                    end
                end
                P_A, P_B: begin
                    if (rx_valid) begin
                        r_tmo_cnt <= '0;
                        if (r_p_state == P_A) r_a <= w_a_shift;
                        else                  r_b <= w_b_shift;
                        if (r_byte_cnt == BCW'(NB - 1)) begin
                            r_byte_cnt <= '0;
                            r_p_state  <= (r_p_state == P_A) ? P_B : P_EXEC;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BCW'(1);
                        end
                    end else if (r_tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        r_tmo_cnt   <= '0;
                        r_byte_cnt  <= '0;
                        r_a         <= '0;
                        r_b         <= '0;
                        r_frame_err <= 1'b1;
                        r_p_state   <= P_OP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
                end
                P_EXEC: begin
                    r_drop     <= w_full;
                    r_tmo_cnt  <= '0;
                    r_byte_cnt <= '0;
                    if (rx_valid) begin
                        r_opcode  <= rx_data;
                        r_p_state <= P_A;
                    end else begin
                        r_p_state <= P_OP;
                    end
                end
                default: r_p_state <= P_OP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Serialiser: status byte first, then result bytes LSB-first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_t_state  <= T_IDLE;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_buf   <= '0;
            r_tx_idx   <= '0;
        end else if (r_t_state == T_IDLE) begin
            if (r_count != '0) begin
                r_tx_data  <= w_head[ENT_W-1 -: 8];
                r_tx_buf   <= w_head[DATA_W-1:0];
                r_tx_idx   <= '0;
                r_tx_valid <= 1'b1;
                r_t_state  <= T_SEND;
            end
        end else if (w_hs) begin
            if (!w_last) begin
                r_tx_data <= r_tx_buf[7:0];
                r_tx_buf  <= r_tx_buf >> 8;
                r_tx_idx  <= r_tx_idx + IW'(1);
            end else if (w_more) begin
                r_tx_data <= w_next[ENT_W-1 -: 8];
                r_tx_buf  <= w_next[DATA_W-1:0];
                r_tx_idx  <= '0;
            end else begin
                r_tx_valid <= 1'b0;
                r_t_state  <= T_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_busy <= 1'b0;
        else      r_busy <= (r_p_state != P_OP) || (r_count != '0) || (r_t_state != T_IDLE);
    end

    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign frame_err = r_frame_err;
    assign drop      = r_drop;
    assign busy      = r_busy;

endmodule
